// File: rtl/acq_controller.sv
// Acquisition sequencer: pre-trigger fill, level/edge trigger, post-trigger capture into a
// circular buffer, configured and commanded over the register Simple Interface bus.
module acq_controller #(
  parameter int unsigned BITS_ADC                 = 8,
  parameter int unsigned REG_DATA_WIDTH           = 16,
  parameter int unsigned REG_ADDR_WIDTH           = 8,
  parameter int unsigned BUF_ADDR_WIDTH           = 10,
  parameter int unsigned ADDR_REQUESTS            = 8,
  parameter int unsigned ADDR_PRETRIGGER          = 9,
  parameter int unsigned ADDR_NUM_SAMPLES         = 10,
  parameter int unsigned ADDR_TRIGGER_VALUE       = 11,
  parameter int unsigned ADDR_TRIGGER_SETTINGS    = 12,
  parameter int unsigned DEFAULT_PRETRIGGER       = 0,
  parameter int unsigned DEFAULT_NUM_SAMPLES      = 2 ** BUF_ADDR_WIDTH,
  parameter int unsigned DEFAULT_TRIGGER_VALUE    = 2 ** (BITS_ADC - 1),
  parameter int unsigned DEFAULT_TRIGGER_SETTINGS = 0
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  input  logic                      reg_si_rdy,
  input  logic [BITS_ADC-1:0]       adc_si_data,
  input  logic                      adc_si_rdy,
  output logic                      wr_en_o,
  output logic [BUF_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [BITS_ADC-1:0]       wr_data_o,
  output logic [BUF_ADDR_WIDTH-1:0] trig_addr_o,
  output logic [BUF_ADDR_WIDTH-1:0] start_addr_o,
  output logic                      armed_o,
  output logic                      triggered_o,
  output logic                      done_o
);

  localparam int unsigned Depth = 2 ** BUF_ADDR_WIDTH;
  localparam int unsigned CW    = BUF_ADDR_WIDTH + 1;
  localparam int unsigned RW    = REG_DATA_WIDTH;
  localparam int unsigned AW    = BUF_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  // Configuration registers
  logic [RW-1:0]       pretrig_q, num_samples_q;
  logic [BITS_ADC-1:0] trig_value_q;
  logic                trig_falling_q;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      pretrig_q      <= RW'(DEFAULT_PRETRIGGER);
      num_samples_q  <= RW'(DEFAULT_NUM_SAMPLES);
      trig_value_q   <= BITS_ADC'(DEFAULT_TRIGGER_VALUE);
      trig_falling_q <= 1'(DEFAULT_TRIGGER_SETTINGS);
    end else if (reg_si_rdy) begin
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_PRETRIGGER)) pretrig_q <= reg_si_data;
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES)) num_samples_q <= reg_si_data;
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_TRIGGER_VALUE)) begin
        trig_value_q <= reg_si_data[BITS_ADC-1:0];
      end
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_TRIGGER_SETTINGS)) trig_falling_q <= reg_si_data[0];
    end
  end

  logic req_hit, req_start, req_stop, req_force, req_clear;
  assign req_hit   = reg_si_rdy && (reg_si_addr == REG_ADDR_WIDTH'(ADDR_REQUESTS));
  assign req_stop  = req_hit && reg_si_data[1];
  assign req_start = req_hit && reg_si_data[0] && !reg_si_data[1];
  assign req_force = req_hit && reg_si_data[2];
  assign req_clear = req_hit && reg_si_data[3];

  // Effective window lengths with N clamped to the buffer depth and P to N-1
  logic [CW-1:0] n_eff, p_eff;
  always_comb begin
    if (num_samples_q > RW'(Depth)) n_eff = CW'(Depth);
    else                            n_eff = CW'(num_samples_q);
    if (pretrig_q >= RW'(n_eff)) p_eff = n_eff - CW'(1);
    else                         p_eff = CW'(pretrig_q);
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]       pre_len_q, pre_len_d, post_len_q, post_len_d;
  logic [BITS_ADC-1:0] level_q, level_d, prev_q, prev_d;
  logic                falling_q, falling_d, have_prev_q, have_prev_d, force_q, force_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d, trig_addr_q, trig_addr_d;
  logic [AW-1:0]       start_addr_q, start_addr_d;
  logic [BITS_ADC-1:0] wr_data_q, wr_data_d;
  logic                armed_q, triggered_q, done_q;
  logic                capturing, edge_hit;

  assign cnt_inc   = cnt_q + CW'(1);
  assign capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
  assign edge_hit  = falling_q ? (prev_q >= level_q) && (adc_si_data < level_q)
                               : (prev_q < level_q) && (adc_si_data >= level_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pre_len_d    = pre_len_q;
    post_len_d   = post_len_q;
    level_d      = level_q;
    falling_d    = falling_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    force_d      = force_q | req_force;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if (req_stop) begin
      state_d = StIdle;
      force_d = 1'b0;
    end else if (req_start && (n_eff != '0)) begin
      // A sample coincident with START is deliberately dropped
      state_d     = (p_eff == '0) ? StWait : StPre;
      cnt_d       = '0;
      addr_d      = '0;
      have_prev_d = 1'b0;
      force_d     = 1'b0;
      pre_len_d   = p_eff;
      post_len_d  = n_eff - p_eff;
      level_d     = trig_value_q;
      falling_d   = trig_falling_q;
    end else if (req_clear && (state_q == StDone)) begin
      state_d = StIdle;
    end else if (adc_si_rdy && capturing) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = addr_q;
      wr_data_d   = adc_si_data;
      addr_d      = addr_q + AW'(1);
      prev_d      = adc_si_data;
      have_prev_d = 1'b1;
      unique case (state_q)
        StPre: begin
          if (cnt_inc == pre_len_q) begin
            state_d = StWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StWait: begin
          if (force_q || (have_prev_q && edge_hit)) begin
            trig_addr_d  = addr_q;
            start_addr_d = addr_q - AW'(pre_len_q);
            force_d      = 1'b0;
            cnt_d        = CW'(1);
            state_d      = (post_len_q == CW'(1)) ? StDone : StPost;
          end
        end
        StPost: begin
          if (cnt_inc == post_len_q) state_d = StDone;
          else                       cnt_d   = cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      post_len_q   <= '0;
      level_q      <= '0;
      falling_q    <= 1'b0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      force_q      <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      armed_q      <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_len_q    <= pre_len_d;
      post_len_q   <= post_len_d;
      level_q      <= level_d;
      falling_q    <= falling_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      force_q      <= force_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      armed_q      <= (state_d == StPre) || (state_d == StWait);
      triggered_q  <= (state_d == StPost) || (state_d == StDone);
      done_q       <= (state_d == StDone);
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign trig_addr_o  = trig_addr_q;
  assign start_addr_o = start_addr_q;
  assign armed_o      = armed_q;
  assign triggered_o  = triggered_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_acq_controller.sv
// Directed bench for acq_controller built with a 16-entry buffer so wrap-around is reachable.
module tb_acq_controller;

  localparam int unsigned Baw = 4;

  logic           clk_i = 1'b0;
  logic           rst;
  logic [15:0]    reg_si_data;
  logic [7:0]     reg_si_addr;
  logic           reg_si_rdy;
  logic [7:0]     adc_si_data;
  logic           adc_si_rdy;
  logic           wr_en_o;
  logic [Baw-1:0] wr_addr_o;
  logic [7:0]     wr_data_o;
  logic [Baw-1:0] trig_addr_o;
  logic [Baw-1:0] start_addr_o;
  logic           armed_o;
  logic           triggered_o;
  logic           done_o;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  acq_controller #(
    .BUF_ADDR_WIDTH(Baw)
  ) dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .reg_si_data (reg_si_data),
    .reg_si_addr (reg_si_addr),
    .reg_si_rdy  (reg_si_rdy),
    .adc_si_data (adc_si_data),
    .adc_si_rdy  (adc_si_rdy),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .trig_addr_o (trig_addr_o),
    .start_addr_o(start_addr_o),
    .armed_o     (armed_o),
    .triggered_o (triggered_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (wr_en_o === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk_i);
    reg_si_rdy  = 1'b1;
    reg_si_addr = a;
    reg_si_data = d;
    @(negedge clk_i);
    reg_si_rdy  = 1'b0;
  endtask

  // Returns on the falling edge after the capturing edge, where the write is visible
  task automatic sample(input logic [7:0] d);
    @(negedge clk_i);
    adc_si_rdy  = 1'b1;
    adc_si_data = d;
    @(negedge clk_i);
    adc_si_rdy  = 1'b0;
  endtask

  task automatic samp_wr(input string tag, input logic [7:0] d, input logic [Baw-1:0] a);
    sample(d);
    check({tag, "_wr_en"}, wr_en_o, 1);
    check({tag, "_wr_addr"}, wr_addr_o, a);
    check({tag, "_wr_data"}, wr_data_o, d);
  endtask

  task automatic samp_nowr(input string tag, input logic [7:0] d);
    sample(d);
    check({tag, "_no_wr"}, wr_en_o, 0);
  endtask

  localparam logic [7:0] AReq = 8, APre = 9, ANum = 10, AVal = 11, ASet = 12;

  initial begin
    rst = 1'b0;
    reg_si_rdy = 1'b0; reg_si_addr = '0; reg_si_data = '0;
    adc_si_rdy = 1'b0; adc_si_data = '0;

    // Reset: samples ignored, outputs zero
    repeat (3) samp_nowr("rst", 8'h55);
    check("rst_addr", wr_addr_o, 0);
    check("rst_outs", {armed_o, triggered_o, done_o, trig_addr_o, start_addr_o}, 0);
    rst = 1'b1;
    samp_nowr("idle", 8'h66);

    // Basic capture: P=4 N=10 level 0x80 rising
    reg_wr(APre, 4); reg_wr(ANum, 10); reg_wr(AVal, 16'h80); reg_wr(ASet, 0);
    wr_cnt = 0;
    reg_wr(AReq, 1);
    check("basic_armed", armed_o, 1);
    for (int i = 0; i < 10; i++) begin
      samp_wr($sformatf("basic%0d", i), 8'(i * 32), Baw'(i));
      if (i == 3) check("basic_pre_trig", triggered_o, 0);
      if (i == 4) begin
        check("basic_trig", {armed_o, triggered_o}, 2'b01);
        check("basic_trig_addr", trig_addr_o, 4);
      end
      if (i == 8) check("basic_not_done", done_o, 0);
      repeat (2) @(negedge clk_i);
    end
    check("basic_done", done_o, 1);
    check("basic_start_addr", start_addr_o, 0);
    samp_nowr("basic_after_done", 8'h11);
    check("basic_wr_cnt", wr_cnt, 10);

    // Wrap-around: P=3 N=8, 23 low samples then the trigger sample at (20+3) mod 16
    reg_wr(APre, 3); reg_wr(ANum, 8);
    reg_wr(AReq, 1);
    check("wrap_done_clr", done_o, 0);
    for (int i = 0; i < 23; i++) samp_wr($sformatf("wrap%0d", i), 8'h10, Baw'(i));
    check("wrap_no_trig", triggered_o, 0);
    samp_wr("wrap_trig", 8'h90, 7);
    check("wrap_trig", triggered_o, 1);
    check("wrap_trig_addr", trig_addr_o, 7);
    for (int i = 0; i < 3; i++) samp_wr($sformatf("wrap_post%0d", i), 8'h90, Baw'(8 + i));
    check("wrap_not_done", done_o, 0);
    samp_wr("wrap_last", 8'h90, 11);
    check("wrap_done", done_o, 1);
    check("wrap_start_addr", start_addr_o, 4);

    // Falling edge with FORCE: P=0 N=4 level 0x40
    reg_wr(APre, 0); reg_wr(ANum, 4); reg_wr(AVal, 16'h40); reg_wr(ASet, 1);
    reg_wr(AReq, 1);
    check("p0_armed", armed_o, 1);
    for (int i = 0; i < 3; i++) samp_wr($sformatf("fall%0d", i), 8'h50, Baw'(i));
    check("fall_no_trig", triggered_o, 0);
    reg_wr(AReq, 4);
    samp_wr("force", 8'h50, 3);
    check("force_trig", triggered_o, 1);
    check("force_trig_addr", trig_addr_o, 3);
    // Repeat without FORCE; first sample has no predecessor
    reg_wr(AReq, 1);
    samp_wr("fall_first", 8'h3F, 0);
    samp_wr("fall_hi", 8'h50, 1);
    check("fall_first_no_trig", triggered_o, 0);
    samp_wr("fall_edge", 8'h3F, 2);
    check("fall_edge_trig", triggered_o, 1);
    check("fall_edge_addr", trig_addr_o, 2);

    // Abort: STOP during POST
    reg_wr(ANum, 8);
    reg_wr(AReq, 1);
    samp_wr("abort0", 8'h50, 0);
    samp_wr("abort1", 8'h30, 1);
    check("abort_post", triggered_o, 1);
    reg_wr(AReq, 2);
    check("stop_flags", {armed_o, triggered_o}, 0);
    samp_nowr("stop", 8'h30);
    // START+STOP together stays idle
    reg_wr(AReq, 3);
    check("start_stop_armed", armed_o, 0);
    samp_nowr("start_stop", 8'h30);
    // Sample coincident with START is dropped
    @(negedge clk_i);
    reg_si_rdy = 1'b1; reg_si_addr = AReq; reg_si_data = 1;
    adc_si_rdy = 1'b1; adc_si_data = 8'h77;
    @(negedge clk_i);
    reg_si_rdy = 1'b0; adc_si_rdy = 1'b0;
    check("coinc_no_wr", wr_en_o, 0);
    check("coinc_armed", armed_o, 1);
    samp_wr("coinc_first", 8'h50, 0);

    // Clamps: N=0 ignores START; P=12 N=8 gives 7 pre samples and 1 post sample
    reg_wr(AReq, 2);
    reg_wr(ANum, 0);
    reg_wr(AReq, 1);
    check("n0_armed", armed_o, 0);
    samp_nowr("n0", 8'h50);
    reg_wr(APre, 12); reg_wr(ANum, 8);
    reg_wr(AReq, 1);
    for (int i = 0; i < 6; i++) samp_wr($sformatf("clamp%0d", i), 8'h50, Baw'(i));
    samp_wr("clamp_pre7", 8'h30, 6);
    check("clamp_pre7_no_trig", triggered_o, 0);
    samp_wr("clamp_hi", 8'h50, 7);
    samp_wr("clamp_trig", 8'h30, 8);
    check("clamp_done", {triggered_o, done_o}, 2'b11);
    check("clamp_trig_addr", trig_addr_o, 8);
    check("clamp_start_addr", start_addr_o, 1);
    reg_wr(AReq, 8);
    check("clear_done", {armed_o, triggered_o, done_o}, 0);

    // Reset mid-capture
    reg_wr(APre, 0);
    reg_wr(AReq, 1);
    samp_wr("mid0", 8'h50, 0);
    @(negedge clk_i);
    rst = 1'b0; adc_si_rdy = 1'b1; adc_si_data = 8'h50;
    @(negedge clk_i);
    adc_si_rdy = 1'b0;
    check("midrst_no_wr", wr_en_o, 0);
    check("midrst_flags", {armed_o, wr_addr_o}, 0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acq_controller.md
# acq_controller

Acquisition sequencer between the ADC sample stream (`si_data_o`/`si_rdy_o` of the ADC block) and the capture buffer. It is configured and commanded through the register Simple Interface bus. It fills a pre-trigger window, waits for a level/edge trigger, captures the post-trigger window into a circular buffer, and reports completion.

## Interface
- BITS_ADC, 8, sample width
- REG_DATA_WIDTH, 16, register bus data width
- REG_ADDR_WIDTH, 8, register bus address width
- BUF_ADDR_WIDTH, 10, buffer address width; buffer depth 2^BUF_ADDR_WIDTH
- ADDR_REQUESTS, 8, command register address
- ADDR_PRETRIGGER, 9, pre-trigger sample count P
- ADDR_NUM_SAMPLES, 10, total samples N
- ADDR_TRIGGER_VALUE, 11, trigger level (low BITS_ADC bits)
- ADDR_TRIGGER_SETTINGS, 12, bit0 edge (0 rising, 1 falling)
- DEFAULT_PRETRIGGER, 0; DEFAULT_NUM_SAMPLES, 2^BUF_ADDR_WIDTH; DEFAULT_TRIGGER_VALUE, 2^(BITS_ADC-1); DEFAULT_TRIGGER_SETTINGS, 0

- clk_i  input  1  system clock; one clock, all logic on its rising edge
- rst  input  1  synchronous reset, active low (0 = reset)
- reg_si_data  input  REG_DATA_WIDTH  register write data
- reg_si_addr  input  REG_ADDR_WIDTH  register write address
- reg_si_rdy  input  1  register write strobe, one cycle per write
- adc_si_data  input  BITS_ADC  sample from ADC block
- adc_si_rdy  input  1  sample valid, one-cycle pulse
- wr_en_o  output  1  buffer write strobe
- wr_addr_o  output  BUF_ADDR_WIDTH  buffer write address
- wr_data_o  output  BITS_ADC  buffer write data
- trig_addr_o  output  BUF_ADDR_WIDTH  buffer address of trigger sample
- start_addr_o  output  BUF_ADDR_WIDTH  buffer address of oldest captured sample
- armed_o  output  1  high in PRE and WAIT_TRIG
- triggered_o  output  1  high in POST and DONE
- done_o  output  1  capture complete, level

## Operation
- Registers: a write with matching address updates the register on the next edge; unmatched addresses are ignored. P, N and the trigger value/edge are copied to shadow registers on START; writes during a capture affect only the next capture.
- REQUESTS bits (self-clearing, act once per write): bit0 START, bit1 STOP, bit2 FORCE_TRIGGER, bit3 CLEAR_DONE.
- Bit STOP beats START in the same write. STOP from any state: go to IDLE, no further writes, clear armed_o/triggered_o.
- START in any state: restart the capture at address 0 and clear done_o.
- N=0: START ignored. If P>=N, P is clamped to N-1. N is clamped to 2^BUF_ADDR_WIDTH.
- States:
  - IDLE: ignore samples.
  - PRE: write each sample; after P samples go to WAIT_TRIG. START with P=0 goes directly to WAIT_TRIG.
  - WAIT_TRIG: write each sample. The trigger fires when the previous sample was below the level and the current sample is at or above it (rising edge). Falling edge is the mirror: previous at or above, current below. The first sample after START has no predecessor and never triggers. FORCE_TRIGGER makes the next sample the trigger. The trigger sample is written, trig_addr_o is latched, and the block moves to POST.
  - POST: the trigger sample counts as post sample 1. After N-P post samples, the block moves to DONE.
  - DONE: ignore samples until START, STOP or CLEAR_DONE; both CLEAR_DONE and STOP go to IDLE.
- wr_addr increments by 1 per write and wraps modulo 2^BUF_ADDR_WIDTH; it does not wrap on N.
- start_addr_o = trig_addr_o - P, modulo 2^BUF_ADDR_WIDTH; it is valid while done_o is high.
- The previous-sample register updates on every accepted sample in PRE, WAIT_TRIG and POST.

## Timing
- Reset (rst=0): state IDLE, all outputs 0, registers at their defaults, wr_addr 0.
- Sample-to-write latency is 1 cycle: adc_si_rdy in cycle t gives wr_en_o, wr_addr_o and wr_data_o in cycle t+1. wr_en_o is a one-cycle pulse.
- A register write in cycle t takes effect in state or configuration at t+1.
- If a sample arrives in the same cycle as START, it is not captured; capture begins with the next sample.
- If a sample arrives in the same cycle as STOP, it is not written.
- done_o, triggered_o and trig_addr_o update in the same cycle as the wr_en_o of the final sample or trigger sample, respectively.
- Reset asserted mid-capture aborts within one cycle; no write occurs in the cycle after reset.

## Test plan
- Reset defaults: hold rst=0 for 3 cycles, then feed samples → no wr_en_o; all outputs 0.
- Basic capture: P=4, N=10, level 0x80, rising edge. START, then feed ramp 0x00, 0x20, …, 0xE0 (one sample per 4 cycles).
  - Trigger fires on 0x80; trig_addr_o=4; start_addr_o=0.
  - 10 writes occur at addresses 0–9; done_o rises with the write at address 9.
- Wrap-around: BUF_ADDR_WIDTH=4, P=3, N=8. Feed 20 constant 0x10 samples in WAIT_TRIG, then 0x90.
  - Addresses wrap 15→0; trigger at address (20+3) mod 16 = 7; start_addr_o=4.
- Falling edge plus FORCE: set falling edge and level 0x40, feed constant 0x50, issue FORCE → the next sample is the trigger and triggered_o rises. A repeat run without FORCE that feeds 0x50 then 0x3F triggers on 0x3F.
- Abort/restart: STOP during POST → armed_o=triggered_o=0 and no further writes. START+STOP in the same write → IDLE. Sample coincident with START → not written, and the first write is at address 0.
- Clamps: N=0 → START ignored. P=12, N=8 → PRE lasts 7 samples and POST 1 sample.
